// File: rtl/ins_buffer_queue.sv
// 16-entry collapsing instruction buffer: up to 4 of the oldest slots retire per cycle,
// survivors compact toward slot 0, then up to 4 new entries land at post-compaction addresses.
module ins_buffer_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INS_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_new_1_vld,
  input  logic [ADDR_W-1:0] ins_new_1_addr,
  input  logic [INS_W-1:0]  ins_new_1_data,
  input  logic              ins_new_2_vld,
  input  logic [ADDR_W-1:0] ins_new_2_addr,
  input  logic [INS_W-1:0]  ins_new_2_data,
  input  logic              ins_new_3_vld,
  input  logic [ADDR_W-1:0] ins_new_3_addr,
  input  logic [INS_W-1:0]  ins_new_3_data,
  input  logic              ins_new_4_vld,
  input  logic [ADDR_W-1:0] ins_new_4_addr,
  input  logic [INS_W-1:0]  ins_new_4_data,
  input  logic              ins_in_1,
  input  logic              ins_in_2,
  input  logic              ins_in_3,
  input  logic              ins_in_4,
  output logic              ins_out_1_vld,
  output logic [INS_W-1:0]  ins_out_1_data,
  output logic              ins_out_2_vld,
  output logic [INS_W-1:0]  ins_out_2_data,
  output logic              ins_out_3_vld,
  output logic [INS_W-1:0]  ins_out_3_data,
  output logic              ins_out_4_vld,
  output logic [INS_W-1:0]  ins_out_4_data,
  output logic [4:0]        ins_count,
  output logic              ins_buf_full,
  output logic              ins_buf_stall,
  output logic              ins_buf_err
);

  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DepthAddr = ADDR_W'(DEPTH);
  localparam logic [4:0]        DepthCnt  = 5'(DEPTH);
  localparam logic [4:0]        StallCnt  = 5'(DEPTH - 4);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [INS_W-1:0] data_q [DEPTH];
  logic [INS_W-1:0] data_d [DEPTH];
  logic [4:0]       count_q, count_d;
  logic             err_q, err_d;

  logic [3:0]        new_vld, rem_req, rem;
  logic [ADDR_W-1:0] new_addr [4];
  logic [INS_W-1:0]  new_data [4];

  logic [DEPTH-1:0] rem_full;
  logic [IdxW-1:0]  shift, dst, idx;
  logic [4:0]       n_rem, base, n_new;
  logic             dup;

  assign new_vld     = {ins_new_4_vld, ins_new_3_vld, ins_new_2_vld, ins_new_1_vld};
  assign new_addr[0] = ins_new_1_addr;
  assign new_addr[1] = ins_new_2_addr;
  assign new_addr[2] = ins_new_3_addr;
  assign new_addr[3] = ins_new_4_addr;
  assign new_data[0] = ins_new_1_data;
  assign new_data[1] = ins_new_2_data;
  assign new_data[2] = ins_new_3_data;
  assign new_data[3] = ins_new_4_data;
  assign rem_req     = {ins_in_4, ins_in_3, ins_in_2, ins_in_1};

  always_comb begin
    valid_d = '0;
    for (int i = 0; i < DEPTH; i++) data_d[i] = '0;
    err_d    = err_q;
    rem      = rem_req & valid_q[3:0];
    rem_full = '0;
    rem_full[3:0] = rem;
    shift    = '0;
    n_rem    = '0;
    dst      = '0;
    idx      = '0;
    dup      = 1'b0;
    n_new    = '0;
    if ((rem_req & ~valid_q[3:0]) != 4'b0) err_d = 1'b1;

    // Compaction: each survivor drops by the number of removed slots below it.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rem_full[i]) begin
        dst          = IdxW'(i) - shift;
        valid_d[dst] = 1'b1;
        data_d[dst]  = data_q[i];
      end
      if (rem_full[i]) begin
        shift = shift + 1'b1;
        n_rem = n_rem + 1'b1;
      end
    end
    base = count_q - n_rem;

    for (int k = 0; k < 4; k++) begin
      if (new_vld[k]) begin
        if (new_addr[k] >= DepthAddr) begin
          err_d = 1'b1;
        end else begin
          dup = 1'b0;
          for (int j = k + 1; j < 4; j++) begin
            if (new_vld[j] && new_addr[j] == new_addr[k]) dup = 1'b1;
          end
          idx = new_addr[k][IdxW-1:0];
          if (dup) begin
            err_d = 1'b1;  // a higher-numbered write owns this slot
          end else if (valid_d[idx]) begin
            data_d[idx] = new_data[k];
            err_d       = 1'b1;
          end else if ((base + n_new) < DepthCnt) begin
            valid_d[idx] = 1'b1;
            data_d[idx]  = new_data[k];
            n_new        = n_new + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
    count_d = base + n_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign ins_out_1_vld  = valid_q[0];
  assign ins_out_2_vld  = valid_q[1];
  assign ins_out_3_vld  = valid_q[2];
  assign ins_out_4_vld  = valid_q[3];
  assign ins_out_1_data = data_q[0];
  assign ins_out_2_data = data_q[1];
  assign ins_out_3_data = data_q[2];
  assign ins_out_4_data = data_q[3];
  assign ins_count      = count_q;
  assign ins_buf_full   = (count_q == DepthCnt);
  assign ins_buf_stall  = (count_q > StallCnt);
  assign ins_buf_err    = err_q;

endmodule
